// File: rtl/otter_fetch_queue.sv
// OTTER fetch front end: owns the fetch PC, issues word reads and
// queues returned instructions with their PCs for decode.
module otter_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_DOUT,
  input  logic        DE_STALL,
  output logic        DE_VALID,
  output logic [31:0] DE_IR,
  output logic [31:0] DE_PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          kill;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;

  logic [31:0] ir_q [DEPTH];
  logic [31:0] pc_q [DEPTH];

  // occupancy counts the read in flight so a return always finds room
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = !RESET && !REDIRECT &&
                 (occ < (CW+1)'(DEPTH));
  assign push  = inflight && !kill;
  assign pop   = DE_VALID && !DE_STALL;

  assign MEM_RDEN = issue;
  assign MEM_ADDR = fetch_pc;

  assign DE_VALID = (count != '0);
  assign DE_IR    = DE_VALID ? ir_q[rd_ptr] : 32'h0;
  assign DE_PC    = DE_VALID ? pc_q[rd_ptr] : 32'h0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC & ~32'h3;
      inflight <= 1'b0;
      kill     <= inflight;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      kill     <= 1'b0;
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RESET && !REDIRECT) begin
      ir_q[wr_ptr] <= MEM_DOUT;
      pc_q[wr_ptr] <= req_pc;
    end
  end

endmodule
